serial_argmax: RTL

Sequential argmax unit that produces the classification `label`/`ready` pair consumed by the MLP test harness. It accepts output-layer neuron results one per cycle as signed fixed-point words. It tracks the running maximum and its index, then presents the winning index on `label` with a one-cycle `ready` pulse. It sits between the output-layer neurons and the wrapper's test-case counter, and is the transmitter side of the label/ready interface.

---
 rtl/serial_argmax.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_argmax.sv
// serial_argmax: sequential argmax over size_of_output_layer signed results.
// Results arrive one per accepted cycle. The index of the largest one is
// presented on label together with a one-cycle ready pulse.
// Optional build macro SERIAL_ARGMAX_MAX_VALUE_EN adds a max_value output,
// which holds the winning result alongside label.
//
// state | meaning
// IDLE  | waiting for start (or a start captured while in DONE)
// ACCUM | collecting results, tracking running best value and index
// DONE  | publish best_idx on label, pulse ready, return to IDLE
module serial_argmax #(
  parameter int n = 16,
  parameter int m = 6,
  parameter int size_of_output_layer = 10,
  parameter int clog2_size_of_output_layer = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic                                  start,
  input  logic                                  in_valid,
  input  logic signed [n-1:0]                   in_value,
  output logic [clog2_size_of_output_layer-1:0] label,
  output logic                                  ready,
  output logic                                  busy
`ifdef SERIAL_ARGMAX_MAX_VALUE_EN
  ,
  output logic [n-1:0]                          max_value
`endif
);

  // The fractional point does not affect a signed compare; only sanity-check it.
  if (m > n - 1) begin : g_bad_frac
    $error("serial_argmax: fractional bits m must be below word width n");
  end
  if ((1 << clog2_size_of_output_layer) < size_of_output_layer) begin : g_bad_idx
    $error("serial_argmax: index width too small for size_of_output_layer");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [clog2_size_of_output_layer-1:0] last_idx =
    clog2_size_of_output_layer'(size_of_output_layer - 1);

  state_t                                state;
  logic [clog2_size_of_output_layer-1:0] idx;
  logic [clog2_size_of_output_layer-1:0] best_idx;
  logic signed [n-1:0]                   best_val;
  logic                                  start_pending;

  // Single-process FSM: running argmax plus registered label/ready/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      best_idx      <= '0;
      best_val      <= '0;
      start_pending <= 1'b0;
      label         <= '0;
      ready         <= 1'b0;
      busy          <= 1'b0;
`ifdef SERIAL_ARGMAX_MAX_VALUE_EN
      max_value     <= '0;
`endif
    end else if (clk_en) begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start || start_pending) begin
            state         <= ACCUM;
            busy          <= 1'b1;
            idx           <= '0;
            best_idx      <= '0;
            best_val      <= '0;
            start_pending <= 1'b0;
          end
        end
        ACCUM: begin
          if (start) begin
            // restart: anything offered on in_valid this cycle is dropped
            idx      <= '0;
            best_idx <= '0;
            best_val <= '0;
          end else if (in_valid) begin
            // first value always loads; later ones only if strictly larger
            if (idx == '0 || in_value > best_val) begin
              best_val <= in_value;
              best_idx <= idx;
            end
            idx <= idx + 1'b1;
            if (idx == last_idx) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          label         <= best_idx;
          ready         <= 1'b1;
`ifdef SERIAL_ARGMAX_MAX_VALUE_EN
          max_value     <= best_val;
`endif
          // a start seen here launches the next classification after IDLE
          start_pending <= start;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
